// File: rtl/ball_pkg.sv
// Shared types and table geometry for the puck controller.
package ball_pkg;

    localparam int unsigned POS_W  = 13;
    localparam int unsigned VEL_W  = 5;
    localparam int unsigned OUT_W  = 12;
    localparam int unsigned HOLD_W = 6;

    typedef logic signed [POS_W-1:0] pos_t;
    typedef logic signed [VEL_W-1:0] vel_t;
    typedef logic [HOLD_W-1:0]       hold_t;

    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StCheck,
        StApply,
        StGoalHold
    } state_e;

    localparam pos_t RADIUS_BALL   = 13'sd10;
    localparam pos_t RADIUS_PADDLE = 13'sd20;
    localparam pos_t TABLE_LEFT    = 13'sd32;
    localparam pos_t TABLE_RIGHT   = 13'sd991;
    localparam pos_t TABLE_TOP     = 13'sd32;
    localparam pos_t TABLE_BOTTOM  = 13'sd735;
    localparam pos_t GOAL_TOP      = 13'sd284;
    localparam pos_t GOAL_BOTTOM   = 13'sd484;
    localparam pos_t CENTER_X      = 13'sd512;
    localparam pos_t CENTER_Y      = 13'sd384;

    localparam vel_t SERVE_SPEED = 5'sd3;
    localparam vel_t HIT_SPEED   = 5'sd6;
    localparam vel_t HIT_SPEED_Y = 5'sd3;

    localparam int unsigned HIT_RADIUS       = 30;  // RADIUS_BALL + RADIUS_PADDLE
    localparam int unsigned GOAL_HOLD_FRAMES = 60;
    localparam hold_t       HOLD_LAST        = hold_t'(GOAL_HOLD_FRAMES - 1);

    // Sign-extend a velocity to position width.
    function automatic pos_t sext_vel(input vel_t v);
        return {{(POS_W-VEL_W){v[VEL_W-1]}}, v};
    endfunction

endpackage

// File: rtl/ball_if.sv
// Paddle inputs and puck outputs exchanged between the controller and the draw/score side.
interface ball_if;
    import ball_pkg::*;

    logic [OUT_W-1:0] xpos_p1;
    logic [OUT_W-1:0] ypos_p1;
    logic [OUT_W-1:0] xpos_p2;
    logic [OUT_W-1:0] ypos_p2;
    logic [OUT_W-1:0] xpos_ball;
    logic [OUT_W-1:0] ypos_ball;
    logic             goal_p1;
    logic             goal_p2;
    logic             in_play;

    modport master (
        input  xpos_p1, ypos_p1, xpos_p2, ypos_p2,
        output xpos_ball, ypos_ball, goal_p1, goal_p2, in_play
    );

    modport slave (
        output xpos_p1, ypos_p1, xpos_p2, ypos_p2,
        input  xpos_ball, ypos_ball, goal_p1, goal_p2, in_play
    );

endinterface

// File: rtl/ball_ctl_circle_hit.sv
// Combinational circle overlap test: dx^2 + dy^2 <= Radius^2.
module circle_hit
    import ball_pkg::*;
#(
    parameter int unsigned Radius = 30
) (
    input  pos_t dx_i,
    input  pos_t dy_i,
    output logic hit_o
);

    typedef logic [2*POS_W-1:0] sq_t;
    typedef logic [2*POS_W:0]   sum_t;

    localparam sum_t LimSq = sum_t'(Radius * Radius);

    logic [POS_W-1:0] adx, ady;
    sq_t              sq_x, sq_y;
    sum_t             sum;

    // Magnitudes, squares and compare against the combined radius squared.
    always_comb begin
        adx   = dx_i[POS_W-1] ? -dx_i : dx_i;
        ady   = dy_i[POS_W-1] ? -dy_i : dy_i;
        sq_x  = {{POS_W{1'b0}}, adx} * {{POS_W{1'b0}}, adx};
        sq_y  = {{POS_W{1'b0}}, ady} * {{POS_W{1'b0}}, ady};
        sum   = {1'b0, sq_x} + {1'b0, sq_y};
        hit_o = (sum <= LimSq);
    end

endmodule

// File: rtl/ball_ctl.sv
// Per-frame puck motion: serve, wall bounce, paddle hit, goal detection and re-serve hold.
module ball_ctl
    import ball_pkg::*;
(
    input  logic   clk_in,
    input  logic   rst,
    input  logic   vblnk_in,
    input  logic   start,
    ball_if.master bus
);

    state_e state_q, state_d;
    pos_t   x_q, x_d, y_q, y_d, nx_q, nx_d, ny_q, ny_d;
    vel_t   vx_q, vx_d, vy_q, vy_d;
    hold_t  hold_q, hold_d;
    logic   serve_neg_q, serve_neg_d, vblnk_prev_q;
    logic   goal_p1_q, goal_p1_d, goal_p2_q, goal_p2_d;
    logic   wl_q, wl_d, wr_q, wr_d, wt_q, wt_d, wb_q, wb_d;
    logic   goal_l_q, goal_l_d, goal_r_q, goal_r_d;
    logic   phit_q, phit_d, pdx_neg_q, pdx_neg_d, pdy_neg_q, pdy_neg_d, pdy_zero_q, pdy_zero_d;

    logic   tick, hit1, hit2, in_span, in_play;
    pos_t   nx, ny, dx1, dy1, dx2, dy2, px_new, py_new;
    vel_t   vx_hit, vy_hit, vx_new, vy_new;

    assign tick = vblnk_in & ~vblnk_prev_q;

    assign nx  = x_q + sext_vel(vx_q);
    assign ny  = y_q + sext_vel(vy_q);
    assign dx1 = x_q - pos_t'({1'b0, bus.xpos_p1});
    assign dy1 = y_q - pos_t'({1'b0, bus.ypos_p1});
    assign dx2 = x_q - pos_t'({1'b0, bus.xpos_p2});
    assign dy2 = y_q - pos_t'({1'b0, bus.ypos_p2});
    assign in_span = (y_q >= GOAL_TOP) && (y_q <= GOAL_BOTTOM);

    circle_hit #(.Radius(HIT_RADIUS)) u_hit_p1 (.dx_i(dx1), .dy_i(dy1), .hit_o(hit1));
    circle_hit #(.Radius(HIT_RADIUS)) u_hit_p2 (.dx_i(dx2), .dy_i(dy2), .hit_o(hit2));

    // State register and all datapath registers, synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= StIdle;
            x_q          <= CENTER_X;
            y_q          <= CENTER_Y;
            vx_q         <= '0;
            vy_q         <= '0;
            nx_q         <= '0;
            ny_q         <= '0;
            hold_q       <= '0;
            serve_neg_q  <= 1'b0;
            vblnk_prev_q <= 1'b0;
            goal_p1_q    <= 1'b0;
            goal_p2_q    <= 1'b0;
            {wl_q, wr_q, wt_q, wb_q, goal_l_q, goal_r_q} <= '0;
            {phit_q, pdx_neg_q, pdy_neg_q, pdy_zero_q}  <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vx_q         <= vx_d;
            vy_q         <= vy_d;
            nx_q         <= nx_d;
            ny_q         <= ny_d;
            hold_q       <= hold_d;
            serve_neg_q  <= serve_neg_d;
            vblnk_prev_q <= vblnk_in;
            goal_p1_q    <= goal_p1_d;
            goal_p2_q    <= goal_p2_d;
            {wl_q, wr_q, wt_q, wb_q, goal_l_q, goal_r_q} <= {wl_d, wr_d, wt_d, wb_d, goal_l_d, goal_r_d};
            {phit_q, pdx_neg_q, pdy_neg_q, pdy_zero_q}  <= {phit_d, pdx_neg_d, pdy_neg_d, pdy_zero_d};
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start) state_d = StPlay;
            StPlay:     if (tick) state_d = StCheck;
            StCheck:    state_d = StApply;
            StApply:    state_d = (goal_l_q | goal_r_q) ? StGoalHold : StPlay;
            StGoalHold: if (tick && hold_q == HOLD_LAST) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_play = (state_q == StPlay) || (state_q == StCheck) || (state_q == StApply);
    end

    // Resolved motion for APPLY: paddle velocity first, then wall reflection and clamp.
    always_comb begin
        vx_hit = pdx_neg_q ? -HIT_SPEED : HIT_SPEED;
        if (pdy_zero_q)     vy_hit = '0;
        else if (pdy_neg_q) vy_hit = -HIT_SPEED_Y;
        else                vy_hit = HIT_SPEED_Y;
        vx_new = phit_q ? vx_hit : vx_q;
        vy_new = phit_q ? vy_hit : vy_q;
        px_new = phit_q ? x_q + sext_vel(vx_hit) : nx_q;
        py_new = phit_q ? y_q + sext_vel(vy_hit) : ny_q;
        if (wl_q) begin
            vx_new = -vx_new;
            px_new = TABLE_LEFT + RADIUS_BALL;
        end else if (wr_q) begin
            vx_new = -vx_new;
            px_new = TABLE_RIGHT - RADIUS_BALL;
        end
        if (wt_q) begin
            vy_new = -vy_new;
            py_new = TABLE_TOP + RADIUS_BALL;
        end else if (wb_q) begin
            vy_new = -vy_new;
            py_new = TABLE_BOTTOM - RADIUS_BALL;
        end
    end

    // Datapath next state per FSM phase.
    always_comb begin
        x_d = x_q;  y_d = y_q;  vx_d = vx_q;  vy_d = vy_q;  nx_d = nx_q;  ny_d = ny_q;
        hold_d = hold_q;  serve_neg_d = serve_neg_q;
        goal_p1_d = 1'b0;  goal_p2_d = 1'b0;
        {wl_d, wr_d, wt_d, wb_d, goal_l_d, goal_r_d} = {wl_q, wr_q, wt_q, wb_q, goal_l_q, goal_r_q};
        {phit_d, pdx_neg_d, pdy_neg_d, pdy_zero_d}  = {phit_q, pdx_neg_q, pdy_neg_q, pdy_zero_q};
        unique case (state_q)
            StIdle: begin
                x_d = CENTER_X;
                y_d = CENTER_Y;
                if (start) begin
                    vx_d = serve_neg_q ? -SERVE_SPEED : SERVE_SPEED;
                    vy_d = 5'sd1;
                end
            end
            StCheck: begin
                nx_d = nx;
                ny_d = ny;
                wl_d = (nx - RADIUS_BALL) < TABLE_LEFT;
                wr_d = (nx + RADIUS_BALL) > TABLE_RIGHT;
                wt_d = (ny - RADIUS_BALL) < TABLE_TOP;
                wb_d = (ny + RADIUS_BALL) > TABLE_BOTTOM;
                goal_l_d = ((nx - RADIUS_BALL) < TABLE_LEFT) && in_span;
                goal_r_d = ((nx + RADIUS_BALL) > TABLE_RIGHT) && in_span;
                // Paddle 1 takes precedence when both overlap.
                phit_d     = hit1 | hit2;
                pdx_neg_d  = hit1 ? dx1[POS_W-1] : dx2[POS_W-1];
                pdy_neg_d  = hit1 ? dy1[POS_W-1] : dy2[POS_W-1];
                pdy_zero_d = hit1 ? (dy1 == '0) : (dy2 == '0);
            end
            StApply: begin
                if (goal_l_q || goal_r_q) begin
                    goal_p2_d   = goal_l_q;
                    goal_p1_d   = ~goal_l_q;
                    serve_neg_d = goal_l_q;
                    x_d  = CENTER_X;
                    y_d  = CENTER_Y;
                    vx_d = '0;
                    vy_d = '0;
                end else begin
                    x_d  = px_new;
                    y_d  = py_new;
                    vx_d = vx_new;
                    vy_d = vy_new;
                end
            end
            StGoalHold: begin
                if (tick) hold_d = (hold_q == HOLD_LAST) ? '0 : hold_q + hold_t'(1);
            end
            default: ;
        endcase
    end

    assign bus.xpos_ball = x_q[OUT_W-1:0];
    assign bus.ypos_ball = y_q[OUT_W-1:0];
    assign bus.goal_p1   = goal_p1_q;
    assign bus.goal_p2   = goal_p2_q;
    assign bus.in_play   = in_play;

endmodule

// File: tb/tb_ball_ctl.sv
// Directed bench for ball_ctl: hand-computed vector table plus model-tracked long sequences.
module tb_ball_ctl;

    logic clk = 1'b0;
    logic rst, vblnk, start;
    int   checks = 0;
    int   errors = 0;
    int   g1_cnt = 0;
    int   g2_cnt = 0;

    // Reference puck state.
    int   mx, my, mvx, mvy, msdir;

    ball_if bus_if ();

    ball_ctl dut (
        .clk_in   (clk),
        .rst      (rst),
        .vblnk_in (vblnk),
        .start    (start),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.goal_p1 === 1'b1) g1_cnt++;
        if (bus_if.goal_p2 === 1'b1) g2_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int p1x, p1y, p2x, p2y;
        int ex, ey;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        mx = 512; my = 384; mvx = 0; mvy = 0; msdir = 1;
    endfunction

    function automatic void model_serve();
        mvx = 3 * msdir; mvy = 1;
    endfunction

    function automatic void model_step(input int p1x, p1y, p2x, p2y);
        int nx, ny, dx, dy, vx, vy, px, py;
        bit h1, h2, wl, wr, wt, wb, span;
        nx = mx + mvx;
        ny = my + mvy;
        h1 = ((mx - p1x) * (mx - p1x) + (my - p1y) * (my - p1y)) <= 900;
        h2 = ((mx - p2x) * (mx - p2x) + (my - p2y) * (my - p2y)) <= 900;
        wl = (nx - 10) < 32;
        wr = (nx + 10) > 991;
        wt = (ny - 10) < 32;
        wb = (ny + 10) > 735;
        span = (my >= 284) && (my <= 484);
        if ((wl || wr) && span) begin
            msdir = wl ? -1 : 1;
            mx = 512; my = 384; mvx = 0; mvy = 0;
            return;
        end
        vx = mvx; vy = mvy; px = nx; py = ny;
        if (h1 || h2) begin
            dx = h1 ? mx - p1x : mx - p2x;
            dy = h1 ? my - p1y : my - p2y;
            vx = (dx >= 0) ? 6 : -6;
            vy = (dy > 0) ? 3 : ((dy < 0) ? -3 : 0);
            px = mx + vx;
            py = my + vy;
        end
        if (wl) begin vx = -vx; px = 42; end
        else if (wr) begin vx = -vx; px = 981; end
        if (wt) begin vy = -vy; py = 42; end
        else if (wb) begin vy = -vy; py = 725; end
        mx = px; my = py; mvx = vx; mvy = vy;
    endfunction

    task automatic set_paddles(input int p1x, p1y, p2x, p2y);
        bus_if.xpos_p1 = 12'(p1x);
        bus_if.ypos_p1 = 12'(p1y);
        bus_if.xpos_p2 = 12'(p2x);
        bus_if.ypos_p2 = 12'(p2y);
    endtask

    task automatic pulse_vblnk();
        @(negedge clk);
        vblnk = 1'b1;
        repeat (4) @(negedge clk);
        vblnk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // One frame with given paddles; DUT position compared to the model afterwards.
    task automatic frame_chk(input string tag, input int p1x, p1y, p2x, p2y);
        @(negedge clk);
        set_paddles(p1x, p1y, p2x, p2y);
        pulse_vblnk();
        model_step(p1x, p1y, p2x, p2y);
        chk({tag, " x"}, int'(bus_if.xpos_ball), mx);
        chk({tag, " y"}, int'(bus_if.ypos_ball), my);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic serve();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_serve();
    endtask

    vec_t tbl[12];
    int   ox, oy, g1_base, g2_base;

    initial begin
        rst = 1'b1; vblnk = 1'b0; start = 1'b0;
        set_paddles(0, 0, 0, 0);
        model_reset();

        // Serve, table-driven paddle interactions incl. the exact-radius boundary.
        tbl[0]  = '{0,   0,   0,   0,   515, 385};
        tbl[1]  = '{0,   0,   0,   0,   518, 386};
        tbl[2]  = '{517, 386, 519, 386, 524, 386};
        tbl[3]  = '{0,   0,   0,   0,   530, 386};
        tbl[4]  = '{0,   0,   531, 388, 524, 383};
        tbl[5]  = '{0,   0,   0,   0,   518, 380};
        tbl[6]  = '{518, 370, 0,   0,   524, 383};
        tbl[7]  = '{540, 383, 0,   0,   518, 383};
        tbl[8]  = '{548, 383, 0,   0,   512, 383};
        tbl[9]  = '{543, 383, 0,   0,   506, 383};
        tbl[10] = '{482, 401, 0,   0,   512, 380};
        tbl[11] = '{0,   0,   0,   0,   518, 377};

        do_reset();
        chk("reset x", int'(bus_if.xpos_ball), 512);
        chk("reset y", int'(bus_if.ypos_ball), 384);
        chk("reset in_play", int'(bus_if.in_play), 0);
        chk("reset goal_p1", int'(bus_if.goal_p1), 0);
        chk("reset goal_p2", int'(bus_if.goal_p2), 0);
        serve();
        chk("serve in_play", int'(bus_if.in_play), 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_paddles(tbl[i].p1x, tbl[i].p1y, tbl[i].p2x, tbl[i].p2y);
            pulse_vblnk();
            chk($sformatf("vec%0d x", i), int'(bus_if.xpos_ball), tbl[i].ex);
            chk($sformatf("vec%0d y", i), int'(bus_if.ypos_ball), tbl[i].ey);
        end

        // Right-wall bounce outside the goal span, with output latency check.
        do_reset();
        serve();
        for (int i = 0; i < 156; i++) frame_chk("wall run", 0, 0, 0, 0);
        frame_chk("wall hit", 0, 0, 0, 0);
        chk("wall clamp x", int'(bus_if.xpos_ball), 981);
        chk("wall clamp y", int'(bus_if.ypos_ball), 541);
        ox = 981; oy = 541;
        @(negedge clk);
        vblnk = 1'b1;
        @(posedge clk); #1;
        chk("latency e0 x", int'(bus_if.xpos_ball), ox);
        @(posedge clk); #1;
        chk("latency e1 x", int'(bus_if.xpos_ball), ox);
        chk("latency e1 y", int'(bus_if.ypos_ball), oy);
        @(posedge clk); #1;
        chk("latency e2 x", int'(bus_if.xpos_ball), 978);
        chk("latency e2 y", int'(bus_if.ypos_ball), 542);
        repeat (3) @(negedge clk);
        vblnk = 1'b0;
        repeat (4) @(negedge clk);
        model_step(0, 0, 0, 0);

        // Steer the puck with paddle 1 into the top-right corner.
        do_reset();
        serve();
        for (int i = 0; i < 18; i++) begin
            frame_chk("steer a", mx + 1, my + 1, 0, 0);
            frame_chk("steer b", mx - 1, my + 1, 0, 0);
        end
        for (int i = 0; i < 78; i++) frame_chk("steer c", mx - 1, my + 1, 0, 0);
        frame_chk("corner", 0, 0, 0, 0);
        chk("corner x", int'(bus_if.xpos_ball), 981);
        chk("corner y", int'(bus_if.ypos_ball), 42);
        frame_chk("after corner", 0, 0, 0, 0);
        chk("after corner x", int'(bus_if.xpos_ball), 975);
        chk("after corner y", int'(bus_if.ypos_ball), 45);

        // Reset while APPLY holds a pending left goal.
        do_reset();
        serve();
        frame_chk("aim left", 513, 384, 0, 0);
        for (int i = 0; i < 77; i++) frame_chk("approach", 0, 0, 0, 0);
        g1_base = g1_cnt; g2_base = g2_cnt;
        @(negedge clk);
        vblnk = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vblnk = 1'b0;
        repeat (6) @(negedge clk);
        model_reset();
        chk("rst apply x", int'(bus_if.xpos_ball), 512);
        chk("rst apply y", int'(bus_if.ypos_ball), 384);
        chk("rst apply in_play", int'(bus_if.in_play), 0);
        chk("rst apply goal_p2 cycles", g2_cnt - g2_base, 0);
        chk("rst apply goal_p1 cycles", g1_cnt - g1_base, 0);

        // Left goal, hold, then re-serve to the left.
        serve();
        frame_chk("aim left 2", 513, 384, 0, 0);
        for (int i = 0; i < 77; i++) frame_chk("approach 2", 0, 0, 0, 0);
        g1_base = g1_cnt; g2_base = g2_cnt;
        frame_chk("goal park", 0, 0, 0, 0);
        chk("goal park x", int'(bus_if.xpos_ball), 512);
        chk("goal park y", int'(bus_if.ypos_ball), 384);
        chk("goal_p2 cycles", g2_cnt - g2_base, 1);
        chk("goal_p1 cycles", g1_cnt - g1_base, 0);
        chk("goal in_play", int'(bus_if.in_play), 0);
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 59; i++) pulse_vblnk();
        repeat (3) @(negedge clk);
        chk("hold in_play", int'(bus_if.in_play), 0);
        chk("hold x", int'(bus_if.xpos_ball), 512);
        pulse_vblnk();
        chk("hold release in_play", int'(bus_if.in_play), 1);
        start = 1'b0;
        model_serve();
        frame_chk("reserve", 0, 0, 0, 0);
        chk("reserve x", int'(bus_if.xpos_ball), 509);
        chk("reserve y", int'(bus_if.ypos_ball), 385);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
